toy_bpu_rob_mp: RTL and testbench

Parametrised fetch reorder buffer for the BPU front end, sitting between PC generation, the ICache return path and the fetch filter. It preallocates one entry per fetch request. It accepts out-of-order ICache returns on `ACK_PORTS` independent channels and lets the bp2 decoder kill one entry or an entry plus everything younger. It retires completed entries in order, silently skipping killed ones. On a front-end flush it drains stale in-flight returns without blocking new allocation longer than necessary.

---
 rtl/toy_bpu_rob_mp.sv | 147 ++++++++++++++
 tb/tb_toy_bpu_rob_mp.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bpu_rob_mp.sv
// Fetch reorder buffer: in-order allocation, out-of-order ICache returns,
// bp2 kills, in-order retirement with silent skip of killed entries.
module toy_bpu_rob_mp #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ACK_PORTS  = 2,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_vld,
  output logic                            alloc_rdy,
  output logic [PTR_W-1:0]                alloc_id,
  input  logic [ACK_PORTS-1:0]            ack_vld,
  input  logic [ACK_PORTS*PTR_W-1:0]      ack_id,
  input  logic [ACK_PORTS*DATA_WIDTH-1:0] ack_pld,
  input  logic                            kill_vld,
  input  logic [PTR_W-1:0]                kill_id,
  input  logic                            kill_younger,
  input  logic                            flush,
  output logic                            flush_done,
  output logic                            deq_vld,
  input  logic                            deq_rdy,
  output logic [DATA_WIDTH-1:0]           deq_pld,
  output logic [PTR_W-1:0]                deq_id,
  output logic [PTR_W:0]                  occupancy
);

  typedef enum logic [2:0] {
    S_FREE, S_PEND, S_DONE, S_KPEND, S_KDONE, S_STALE
  } ent_e;

  ent_e                  st_q [DEPTH];
  ent_e                  st_d [DEPTH];
  logic [DATA_WIDTH-1:0] pld_q [DEPTH];
  logic [DATA_WIDTH-1:0] ack_data [DEPTH];
  logic [DEPTH-1:0]      ack_hit;
  logic [DEPTH-1:0]      kill_hit;
  logic [DEPTH-1:0]      pld_we;
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      wr_idx, rd_idx, kill_off;
  logic                  alloc_fire, head_deq, head_skip, kill_ok, any_stale;

  assign wr_idx     = wr_ptr[PTR_W-1:0];
  assign rd_idx     = rd_ptr[PTR_W-1:0];
  assign occupancy  = wr_ptr - rd_ptr;
  assign alloc_rdy  = ~flush && (st_q[wr_idx] == S_FREE);
  assign alloc_id   = wr_idx;
  assign alloc_fire = alloc_vld && alloc_rdy;
  assign deq_vld    = (st_q[rd_idx] == S_DONE);
  assign deq_id     = rd_idx;
  assign deq_pld    = pld_q[rd_idx];
  assign head_deq   = deq_vld && deq_rdy;
  assign head_skip  = (st_q[rd_idx] == S_KDONE);
  assign flush_done = ~any_stale;

  // Kill is only honoured for ids inside the live window [rd_ptr, wr_ptr)
  assign kill_off = kill_id - rd_idx;
  assign kill_ok  = kill_vld && ({1'b0, kill_off} < occupancy);

  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    logic [PTR_W-1:0] ent_off;
    assign ent_off     = PTR_W'(g) - rd_idx;
    assign kill_hit[g] = kill_ok && ((ent_off == kill_off) ||
                         (kill_younger && (ent_off > kill_off) &&
                          ({1'b0, ent_off} < occupancy)));
  end

  // Per-entry ack decode and payload select across return ports
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < DEPTH; i++) ack_data[i] = '0;
    for (int p = 0; p < ACK_PORTS; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ack_vld[p] && (ack_id[p*PTR_W +: PTR_W] == PTR_W'(i))) begin
          ack_hit[i]  = 1'b1;
          ack_data[i] = ack_pld[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    any_stale = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_stale = any_stale | (st_q[i] == S_STALE);
  end

  // Entry next-state; flush takes priority over kill/alloc/dequeue
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]   = st_q[i];
      pld_we[i] = 1'b0;
      if (flush) begin
        case (st_q[i])
          S_PEND, S_KPEND: st_d[i] = ack_hit[i] ? S_FREE : S_STALE;
          S_DONE, S_KDONE: st_d[i] = S_FREE;
          S_STALE:         if (ack_hit[i]) st_d[i] = S_FREE;
          default:         st_d[i] = S_FREE;
        endcase
      end else begin
        case (st_q[i])
          S_FREE:  if (alloc_fire && (wr_idx == PTR_W'(i))) st_d[i] = S_PEND;
          S_PEND: begin
            if (ack_hit[i]) begin
              pld_we[i] = 1'b1;
              st_d[i]   = kill_hit[i] ? S_KDONE : S_DONE;
            end else if (kill_hit[i]) begin
              st_d[i] = S_KPEND;
            end
          end
          S_KPEND: begin
            if (ack_hit[i]) begin
              pld_we[i] = 1'b1;
              st_d[i]   = S_KDONE;
            end
          end
          S_DONE: begin
            if (head_deq && (rd_idx == PTR_W'(i))) st_d[i] = S_FREE;
            else if (kill_hit[i])                 st_d[i] = S_KDONE;
          end
          S_KDONE: if (rd_idx == PTR_W'(i)) st_d[i] = S_FREE;
          S_STALE: if (ack_hit[i]) st_d[i] = S_FREE;
          default: st_d[i] = S_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= S_FREE;
        pld_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= st_d[i];
        if (pld_we[i]) pld_q[i] <= ack_data[i];
      end
      wr_ptr <= wr_ptr + (PTR_W+1)'(alloc_fire);
      rd_ptr <= flush ? wr_ptr : rd_ptr + (PTR_W+1)'(head_deq || head_skip);
    end
  end

endmodule

// File: tb/tb_toy_bpu_rob_mp.sv
// Directed + randomized bench for toy_bpu_rob_mp against a queue-based model.
module tb_toy_bpu_rob_mp;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 256;
  localparam int unsigned AP    = 2;
  localparam int unsigned PW    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alloc_vld, alloc_rdy;
  logic [PW-1:0]     alloc_id;
  logic [AP-1:0]     ack_vld;
  logic [AP*PW-1:0]  ack_id;
  logic [AP*DW-1:0]  ack_pld;
  logic              kill_vld, kill_younger, flush, flush_done;
  logic [PW-1:0]     kill_id;
  logic              deq_vld, deq_rdy;
  logic [DW-1:0]     deq_pld;
  logic [PW-1:0]     deq_id;
  logic [PW:0]       occupancy;

  always #5 clk = ~clk;

  toy_bpu_rob_mp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ACK_PORTS(AP)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
    .ack_vld(ack_vld), .ack_id(ack_id), .ack_pld(ack_pld),
    .kill_vld(kill_vld), .kill_id(kill_id), .kill_younger(kill_younger),
    .flush(flush), .flush_done(flush_done),
    .deq_vld(deq_vld), .deq_rdy(deq_rdy), .deq_pld(deq_pld), .deq_id(deq_id),
    .occupancy(occupancy)
  );

  // Model: live window as an ordered queue plus a set of slots awaiting stale acks
  typedef struct {
    int            id;
    bit            acked;
    bit            killed;
    logic [DW-1:0] pld;
  } ent_t;

  ent_t live[$];
  bit   stale [DEPTH];
  int   wr, rd;
  int   deq_log[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy();
    return !flush && (live.size() < int'(DEPTH)) && !stale[wr % DEPTH];
  endfunction

  function automatic bit m_any_stale();
    for (int i = 0; i < DEPTH; i++) if (stale[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int loc(input int id);
    return (id - (rd % DEPTH) + DEPTH) % DEPTH;
  endfunction

  function automatic bit acked_now(input int id);
    for (int p = 0; p < AP; p++)
      if (ack_vld[p] && int'(ack_id[p*PW +: PW]) == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] rand_pld();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (live.size() > 0) && live[0].acked && !live[0].killed;
    chk("alloc_rdy",  DW'(alloc_rdy),  DW'(m_rdy()));
    chk("alloc_id",   DW'(alloc_id),   DW'(wr % DEPTH));
    chk("deq_vld",    DW'(deq_vld),    DW'(ev));
    chk("deq_id",     DW'(deq_id),     DW'(rd % DEPTH));
    chk("occupancy",  DW'(occupancy),  DW'(live.size()));
    chk("flush_done", DW'(flush_done), DW'(!m_any_stale()));
    if (ev) chk("deq_pld", deq_pld, live[0].pld);
  endtask

  task automatic model_update();
    bit fire, hd, hs;
    int id, k, n;
    ent_t e;
    fire = alloc_vld && m_rdy();
    if (flush) begin
      for (int p = 0; p < AP; p++)
        if (ack_vld[p]) begin
          id = int'(ack_id[p*PW +: PW]);
          if (stale[id]) stale[id] = 1'b0;
        end
      foreach (live[j])
        if (!live[j].acked && !acked_now(live[j].id)) stale[live[j].id] = 1'b1;
      live.delete();
      rd = wr;
    end else begin
      hd = (live.size() > 0) && live[0].acked && !live[0].killed && deq_rdy;
      hs = (live.size() > 0) && live[0].acked && live[0].killed;
      for (int p = 0; p < AP; p++)
        if (ack_vld[p]) begin
          id = int'(ack_id[p*PW +: PW]);
          if (stale[id]) stale[id] = 1'b0;
          else begin
            k = loc(id);
            if (k < live.size()) begin
              live[k].acked = 1'b1;
              live[k].pld   = ack_pld[p*DW +: DW];
            end
          end
        end
      if (kill_vld) begin
        k = loc(int'(kill_id));
        n = live.size();
        if (k < n)
          for (int j = k; j < n; j++)
            if (j == k || kill_younger) live[j].killed = 1'b1;
      end
      if (hd || hs) begin
        void'(live.pop_front());
        rd++;
      end
      if (fire) begin
        e.id = wr % DEPTH; e.acked = 1'b0; e.killed = 1'b0; e.pld = '0;
        live.push_back(e);
        wr++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (deq_vld && deq_rdy && !flush) deq_log.push_back(int'(deq_id));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    alloc_vld = 0; ack_vld = '0; ack_id = '0; ack_pld = '0;
    kill_vld = 0; kill_id = '0; kill_younger = 0; flush = 0; deq_rdy = 1;
  endtask

  task automatic set_ack(input int p, input int id, input logic [DW-1:0] pld);
    ack_vld[p]          = 1'b1;
    ack_id[p*PW +: PW]  = PW'(id);
    ack_pld[p*DW +: DW] = pld;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_alloc_rdy",  DW'(alloc_rdy),  DW'(1));
    chk("rst_alloc_id",   DW'(alloc_id),   DW'(0));
    chk("rst_deq_vld",    DW'(deq_vld),    DW'(0));
    chk("rst_deq_id",     DW'(deq_id),     DW'(0));
    chk("rst_deq_pld",    deq_pld,         DW'(0));
    chk("rst_occupancy",  DW'(occupancy),  DW'(0));
    chk("rst_flush_done", DW'(flush_done), DW'(1));
    live.delete(); deq_log.delete();
    for (int i = 0; i < DEPTH; i++) stale[i] = 1'b0;
    wr = 0; rd = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n);
    alloc_vld = 1;
    repeat (n) step();
    alloc_vld = 0;
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk({tag, "_len"}, DW'(deq_log.size()), DW'(exp.size()));
    foreach (exp[i])
      if (i < deq_log.size()) chk(tag, DW'(deq_log[i]), DW'(exp[i]));
  endtask

  task automatic rand_inputs();
    int c[$];
    int k;
    idle();
    alloc_vld = ($urandom % 4) != 0;
    deq_rdy   = ($urandom % 4) != 0;
    flush     = ($urandom % 80) == 0;
    if ($urandom % 12 == 0) begin
      kill_vld     = 1;
      kill_id      = PW'($urandom);
      kill_younger = 1'($urandom % 2);
      if (live.size() == int'(DEPTH) && int'(kill_id) == rd % DEPTH) kill_younger = 0;
    end
    foreach (live[j]) if (!live[j].acked) c.push_back(live[j].id);
    for (int i = 0; i < DEPTH; i++) if (stale[i]) c.push_back(i);
    for (int p = 0; p < AP; p++)
      if (c.size() > 0 && ($urandom % 2) != 0) begin
        k = $urandom_range(c.size() - 1, 0);
        set_ack(p, c[k], rand_pld());
        c.delete(k);
      end
  endtask

  initial begin
    int e[$];
    rst_n = 0;
    idle();

    // In-order fill, full stall, wrap-around
    do_reset();
    alloc_n(16);
    chk("full_alloc_rdy", DW'(alloc_rdy), DW'(0));
    chk("full_occupancy", DW'(occupancy), DW'(16));
    for (int i = 0; i < 16; i++) begin
      idle(); set_ack(0, i, rand_pld()); step();
    end
    idle(); step(); step();
    e.delete(); for (int i = 0; i < 16; i++) e.push_back(i);
    chk_log("fill_order", e);
    chk("wrap_alloc_id", DW'(alloc_id), DW'(0));
    alloc_n(1);
    chk("wrap_occupancy", DW'(occupancy), DW'(1));

    // Out-of-order returns on two ports
    do_reset();
    alloc_n(4);
    idle(); set_ack(0, 3, rand_pld()); set_ack(1, 1, rand_pld()); step();
    idle(); step();
    idle(); set_ack(0, 0, rand_pld()); step();
    chk("ooo_first_vld", DW'(deq_vld), DW'(1));
    chk("ooo_first_id", DW'(deq_id), DW'(0));
    idle(); set_ack(0, 2, rand_pld()); step();
    idle(); repeat (4) step();
    e = '{0, 1, 2, 3};
    chk_log("ooo_order", e);

    // Single kill
    do_reset();
    alloc_n(3);
    idle(); kill_vld = 1; kill_id = 4'd1; step();
    idle(); set_ack(0, 0, rand_pld()); set_ack(1, 1, rand_pld()); step();
    idle(); set_ack(0, 2, rand_pld()); step();
    idle(); repeat (4) step();
    e = '{0, 2};
    chk_log("kill1_order", e);
    chk("kill1_occupancy", DW'(occupancy), DW'(0));

    // Kill younger with same-cycle allocation
    do_reset();
    alloc_n(6);
    idle(); kill_vld = 1; kill_id = 4'd2; kill_younger = 1; alloc_vld = 1; step();
    for (int i = 0; i < 7; i += 2) begin
      idle(); set_ack(0, i, rand_pld());
      if (i + 1 < 7) set_ack(1, i + 1, rand_pld());
      step();
    end
    idle(); repeat (8) step();
    e = '{0, 1, 6};
    chk_log("killy_order", e);
    chk("killy_occupancy", DW'(occupancy), DW'(0));

    // Flush drain
    do_reset();
    deq_rdy = 0;
    alloc_n(16);
    for (int i = 0; i < 8; i += 2) begin
      idle(); deq_rdy = 0; set_ack(0, i, rand_pld()); set_ack(1, i + 1, rand_pld()); step();
    end
    idle(); deq_rdy = 0; flush = 1; alloc_vld = 1;
    #1;
    chk("flush_alloc_rdy", DW'(alloc_rdy), DW'(0));
    step();
    idle(); deq_rdy = 0;
    chk("flush_occupancy", DW'(occupancy), DW'(0));
    chk("flush_done_low", DW'(flush_done), DW'(0));
    alloc_n(8);
    chk("stale_block_id", DW'(alloc_id), DW'(8));
    chk("stale_block_rdy", DW'(alloc_rdy), DW'(0));
    alloc_n(1);
    chk("stale_block_occ", DW'(occupancy), DW'(8));
    idle(); deq_rdy = 0; set_ack(0, 8, rand_pld()); step();
    chk("stale_release_rdy", DW'(alloc_rdy), DW'(1));
    for (int i = 9; i < 16; i += 2) begin
      idle(); deq_rdy = 0; set_ack(0, i, rand_pld());
      if (i + 1 < 16) set_ack(1, i + 1, rand_pld());
      step();
    end
    chk("flush_done_high", DW'(flush_done), DW'(1));
    for (int i = 0; i < 8; i += 2) begin
      idle(); set_ack(0, i, rand_pld()); set_ack(1, i + 1, rand_pld()); step();
    end
    idle(); repeat (10) step();
    chk("flush_drain_occ", DW'(occupancy), DW'(0));

    // Collisions on the head
    do_reset();
    alloc_n(2);
    idle(); set_ack(0, 0, rand_pld()); kill_vld = 1; kill_id = 4'd0; step();
    chk("ackkill_no_vld", DW'(deq_vld), DW'(0));
    chk("ackkill_occ", DW'(occupancy), DW'(2));
    idle(); step();
    chk("ackkill_skip_id", DW'(deq_id), DW'(1));
    chk("ackkill_skip_occ", DW'(occupancy), DW'(1));
    idle(); set_ack(0, 1, rand_pld()); step();
    chk("hskill_vld", DW'(deq_vld), DW'(1));
    idle(); kill_vld = 1; kill_id = 4'd1; step();
    e = '{1};
    chk_log("hskill_log", e);
    chk("hskill_occ", DW'(occupancy), DW'(0));

    // Randomized traffic, then a mid-operation reset and more traffic
    do_reset();
    repeat (3000) begin rand_inputs(); step(); end
    do_reset();
    repeat (300) begin rand_inputs(); step(); end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
